// File: rtl/kernel_ctrl_pkg.sv
// kernel_ctrl_pkg: shared widths and controller state encoding for the X kernel stream controller.
package kernel_ctrl_pkg;
    localparam int DATA_W = 8;
    localparam int RES_W  = 9;
    typedef enum logic [2:0] {IDLE, PRIME, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/kernel_line_buffer_pair.sv
// kernel_line_buffer_pair: two previous-row buffers sharing one column index; a write shifts new into old.
module kernel_line_buffer_pair
    import kernel_ctrl_pkg::*;
#(
    parameter int MAX_W = 64,
    parameter int AW    = (MAX_W > 1) ? $clog2(MAX_W) : 1
) (
    input  logic              clk,
    input  logic [AW-1:0]     idx,
    input  logic [DATA_W-1:0] din,
    input  logic              wr_en,
    output logic [DATA_W-1:0] old_q,
    output logic [DATA_W-1:0] new_q
);
    logic [DATA_W-1:0] lb_old [MAX_W];
    logic [DATA_W-1:0] lb_new [MAX_W];

    assign old_q = lb_old[idx];
    assign new_q = lb_new[idx];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            lb_old[idx] <= lb_new[idx];
            lb_new[idx] <= din;
        end
    end
endmodule

// File: rtl/kernel_x_stream_controller.sv
// kernel_x_stream_controller: streams 3-row vertical columns to an X kernel cell and forwards its results.
module kernel_x_stream_controller
    import kernel_ctrl_pkg::*;
#(
    parameter int MAX_W        = 64,
    parameter int DRAIN_CYCLES = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [$clog2(MAX_W+1)-1:0] cfg_width,
    input  logic [15:0]                cfg_height,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    input  logic [DATA_W-1:0]          pix_in,
    input  logic                       pix_in_val,
    output logic                       pix_in_rdy,
    output logic [DATA_W-1:0]          x1,
    output logic [DATA_W-1:0]          x2,
    output logic [DATA_W-1:0]          x3,
    output logic                       x1_val,
    output logic                       x2_val,
    output logic                       x3_val,
    output logic                       new_row,
    input  logic [RES_W-1:0]           result,
    input  logic                       result_val,
    output logic [RES_W-1:0]           out_msg,
    output logic                       out_val,
    output logic [31:0]                res_count
);
    localparam int CW = $clog2(MAX_W + 1);
    localparam int AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;
    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    state_t            state;
    logic [CW-1:0]     w_q, col;
    logic [15:0]       h_q, row;
    logic [DW-1:0]     idle;
    logic [DATA_W-1:0] rd_old, rd_new;
    logic              accept, col_end, last_prime, last_run, cfg_bad;

    assign accept     = pix_in_val & pix_in_rdy;
    assign col_end    = col == w_q - CW'(1);
    assign last_prime = row == 16'd1 && col_end;
    assign last_run   = row == h_q - 16'd1 && col_end;
    assign cfg_bad    = cfg_width == '0 || cfg_width > CW'(MAX_W) || cfg_height < 16'd3;

    kernel_line_buffer_pair #(.MAX_W(MAX_W), .AW(AW)) u_lb (
        .clk   (clk),
        .idx   (col[AW-1:0]),
        .din   (pix_in),
        .wr_en (accept),
        .old_q (rd_old),
        .new_q (rd_new)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            pix_in_rdy <= 1'b0;
            x1         <= '0;
            x2         <= '0;
            x3         <= '0;
            x1_val     <= 1'b0;
            x2_val     <= 1'b0;
            x3_val     <= 1'b0;
            new_row    <= 1'b0;
            out_msg    <= '0;
            out_val    <= 1'b0;
            res_count  <= '0;
            w_q        <= '0;
            h_q        <= '0;
            col        <= '0;
            row        <= '0;
            idle       <= '0;
        end else begin
            done    <= 1'b0;
            x1_val  <= 1'b0;
            x2_val  <= 1'b0;
            x3_val  <= 1'b0;
            new_row <= 1'b0;
            out_val <= result_val;
            if (result_val) begin
                out_msg   <= result;
                res_count <= res_count + 32'd1;
            end
            case (state)
                IDLE: if (start) begin
                    if (cfg_bad) begin
                        state <= DONE;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end else begin
                        state      <= PRIME;
                        w_q        <= cfg_width;
                        h_q        <= cfg_height;
                        col        <= '0;
                        row        <= '0;
                        res_count  <= '0;
                        err        <= 1'b0;
                        busy       <= 1'b1;
                        pix_in_rdy <= 1'b1;
                    end
                end
                PRIME, RUN: if (accept) begin
                    col <= col_end ? '0 : col + CW'(1);
                    row <= col_end ? row + 16'd1 : row;
                    if (state == RUN) begin
                        x1      <= rd_old;
                        x2      <= rd_new;
                        x3      <= pix_in;
                        x1_val  <= 1'b1;
                        x2_val  <= 1'b1;
                        x3_val  <= 1'b1;
                        new_row <= col == '0;
                    end
                    if (state == PRIME && last_prime) state <= RUN;
                    if (state == RUN && last_run) begin
                        state      <= DRAIN;
                        pix_in_rdy <= 1'b0;
                        idle       <= '0;
                    end
                end
                DRAIN: begin
                    if (result_val) idle <= '0;
                    else if (idle == DW'(DRAIN_CYCLES - 1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else idle <= idle + DW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_kernel_x_stream_controller.sv
// tb_kernel_x_stream_controller: scoreboard bench with an inline X kernel cell model (x1 + x3, 1-cycle latency).
module tb_kernel_x_stream_controller;
    localparam int MAX_W = 64;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [6:0]  cfg_width;
    logic [15:0] cfg_height;
    logic        busy, done, err;
    logic [7:0]  pix_in;
    logic        pix_in_val, pix_in_rdy;
    logic [7:0]  x1, x2, x3;
    logic        x1_val, x2_val, x3_val, new_row;
    logic [8:0]  result, out_msg;
    logic        result_val, out_val;
    logic [31:0] res_count;

    kernel_x_stream_controller #(.MAX_W(MAX_W), .DRAIN_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .start(start), .cfg_width(cfg_width), .cfg_height(cfg_height),
        .busy(busy), .done(done), .err(err), .pix_in(pix_in), .pix_in_val(pix_in_val),
        .pix_in_rdy(pix_in_rdy), .x1(x1), .x2(x2), .x3(x3), .x1_val(x1_val), .x2_val(x2_val),
        .x3_val(x3_val), .new_row(new_row), .result(result), .result_val(result_val),
        .out_msg(out_msg), .out_val(out_val), .res_count(res_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            result     <= '0;
            result_val <= 1'b0;
        end else begin
            result     <= {1'b0, x1} + {1'b0, x3};
            result_val <= x1_val;
        end
    end

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        logic       nr;
    } iss_t;

    iss_t       iq[$];
    logic [8:0] rq[$];
    int         n_chk = 0, n_fail = 0, n_done = 0, n_out = 0;
    logic [7:0] p2 [MAX_W];
    logic [7:0] p1 [MAX_W];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        iss_t e;
        if (!reset) begin
            if (done) n_done++;
            if (x1_val | x2_val | x3_val) begin
                chk("tap_val_equal", {29'd0, x1_val, x2_val, x3_val}, 32'd7);
                if (iq.size() == 0) chk("unexpected_issue", 1, 0);
                else begin
                    e = iq.pop_front();
                    chk("x1", x1, e.a);
                    chk("x2", x2, e.b);
                    chk("x3", x3, e.c);
                    chk("new_row", new_row, e.nr);
                end
            end
            if (out_val) begin
                n_out++;
                if (rq.size() == 0) chk("unexpected_out", 1, 0);
                else chk("out_msg", out_msg, rq.pop_front());
            end
        end
    end

    task automatic push_pix(input logic [7:0] p, input int gap);
        int t = 0;
        pix_in_val = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        pix_in     = p;
        pix_in_val = 1'b1;
        while (1) begin
            @(negedge clk);
            if (pix_in_rdy) break;
            if (++t > 100) begin chk("pix_rdy_timeout", 0, 1); break; end
        end
        @(posedge clk); #1;
        pix_in_val = 1'b0;
    endtask

    task automatic send_frame(input int w, input int h, input int base, input bit gaps,
                              input bit model, input int npix);
        logic [7:0] p;
        int k = 0;
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++) begin
                if (k >= npix) return;
                p = 8'(base + r * w + c);
                if (model && r >= 2) begin
                    iq.push_back({p2[c], p1[c], p, c == 0});
                    rq.push_back({1'b0, p2[c]} + {1'b0, p});
                end
                p2[c] = p1[c];
                p1[c] = p;
                push_pix(p, gaps ? int'($urandom_range(0, 2)) : 0);
                k++;
            end
    endtask

    task automatic start_frame(input int w, input int h);
        cfg_width  = 7'(w);
        cfg_height = 16'(h);
        @(posedge clk); #1;
        start = 1'b1;
        n_out = 0;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input logic exp_err, input int exp_cnt);
        int t = 0;
        do begin @(negedge clk); t++; end while (!done && t < 3000);
        chk("done_seen", done, 1);
        chk("err", err, exp_err);
        chk("busy_at_done", busy, 0);
        chk("issues_left", iq.size(), 0);
        if (!exp_err) begin
            chk("res_count", res_count, exp_cnt);
            chk("out_pulses", n_out, exp_cnt);
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_rdy", pix_in_rdy, 0);
        chk("rst_xval", {x1_val, x2_val, x3_val, new_row, out_val}, 0);
        chk("rst_x", {x1, x2, x3}, 0);
        chk("rst_out_msg", out_msg, 0);
        chk("rst_res_count", res_count, 0);
    endtask

    initial begin
        int nd0;
        reset = 1'b1; start = 1'b0; cfg_width = '0; cfg_height = '0;
        pix_in = '0; pix_in_val = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs();
        reset = 1'b0;

        start_frame(4, 3);
        for (int c = 0; c < 4; c++) begin
            iq.push_back({8'(c), 8'(c + 4), 8'(c + 8), c == 0});
            rq.push_back(9'(2 * c + 8));
        end
        send_frame(4, 3, 0, 0, 0, 1000);
        wait_done(1'b0, 4);

        start_frame(3, 5);
        send_frame(3, 5, 50, 1, 1, 1000);
        wait_done(1'b0, 9);

        for (int i = 0; i < 3; i++) begin
            if (i == 0) start_frame(0, 5);
            else if (i == 1) start_frame(MAX_W + 1, 5);
            else start_frame(4, 2);
            @(negedge clk);
            chk("bad_done", done, 1);
            chk("bad_err", err, 1);
            chk("bad_busy", busy, 0);
            repeat (3) begin
                @(negedge clk);
                chk("bad_rdy", pix_in_rdy, 0);
                chk("bad_busy_hold", busy, 0);
            end
            chk("err_held", err, 1);
        end

        start_frame(MAX_W, 4);
        send_frame(MAX_W, 4, 0, 0, 1, 1000);
        wait_done(1'b0, 2 * MAX_W);

        start_frame(4, 5);
        send_frame(4, 5, 100, 0, 1, 11);
        reset = 1'b1;
        #1;
        chk_reset_outputs();
        iq.delete();
        rq.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        start_frame(2, 3);
        iq.push_back({8'd200, 8'd202, 8'd204, 1'b1});
        iq.push_back({8'd201, 8'd203, 8'd205, 1'b0});
        rq.push_back(9'd404);
        rq.push_back(9'd406);
        send_frame(2, 3, 200, 0, 0, 1000);
        wait_done(1'b0, 2);

        start_frame(3, 4);
        nd0 = n_done;
        fork
            send_frame(3, 4, 10, 0, 1, 1000);
            begin
                repeat (8) @(posedge clk);
                #1;
                cfg_width = 7'd1;
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
        join
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(1'b0, 6);
        repeat (20) @(negedge clk);
        chk("single_done", n_done - nd0, 1);
        chk("idle_after_done", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
